// File: rtl/writeback_arbiter.sv
// writeback_arbiter: buffers results from four producers (ALU, MUL, LSU,
// branch) in per-source FIFOs and drains them onto three registered
// writeback broadcast ports. A round-robin scan picks which sources are
// drained each cycle.
//
// Ports:
//   clk                   rising-edge clock
//   rst                   asynchronous active-low reset
//   flush                 synchronous clear of all buffered results
//   srcK_en/vregid/val    producer K result (K = 0..3)
//   srcK_almost_full      FIFO K count >= DEPTH-1 (combinational)
//   writebackN_*          registered broadcast N (N = 1..3)
//   overflow              sticky: a result was dropped on a full FIFO
module writeback_arbiter #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        src0_en,
   input  logic [4:0]  src0_vregid,
   input  logic [31:0] src0_val,
   input  logic        src1_en,
   input  logic [4:0]  src1_vregid,
   input  logic [31:0] src1_val,
   input  logic        src2_en,
   input  logic [4:0]  src2_vregid,
   input  logic [31:0] src2_val,
   input  logic        src3_en,
   input  logic [4:0]  src3_vregid,
   input  logic [31:0] src3_val,
   output logic        src0_almost_full,
   output logic        src1_almost_full,
   output logic        src2_almost_full,
   output logic        src3_almost_full,
   output logic        writeback1_en,
   output logic [4:0]  writeback1_vregid,
   output logic [31:0] writeback1_val,
   output logic        writeback2_en,
   output logic [4:0]  writeback2_vregid,
   output logic [31:0] writeback2_val,
   output logic        writeback3_en,
   output logic [4:0]  writeback3_vregid,
   output logic [31:0] writeback3_val,
   output logic        overflow
);

   localparam int unsigned NSRC = 4;
   localparam int unsigned NWB  = 3;
   localparam int unsigned VW   = 5;
   localparam int unsigned DW   = 32;
   localparam int unsigned EW   = VW + DW;
   localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW   = AW + 1;

   // FIFO state; storage is intentionally left unreset
   logic [EW-1:0] r_mem   [NSRC][DEPTH];
   logic [AW-1:0] r_wptr  [NSRC];
   logic [AW-1:0] r_rptr  [NSRC];
   logic [CW-1:0] r_count [NSRC];
   logic [1:0]    r_rr;
   logic          r_overflow;

   logic          r_wb_en     [NWB];
   logic [VW-1:0] r_wb_vregid [NWB];
   logic [DW-1:0] r_wb_val    [NWB];

   logic [NSRC-1:0] w_push_en;
   logic [EW-1:0]   w_push_data [NSRC];
   logic [NSRC-1:0] w_grant;
   logic [NSRC-1:0] w_push_acc;
   logic [NSRC-1:0] w_drop;
   logic [1:0]      w_sel     [NWB];
   logic            w_sel_vld [NWB];
   logic [1:0]      w_rr_next;

   assign w_push_en      = {src3_en, src2_en, src1_en, src0_en};
   assign w_push_data[0] = {src0_vregid, src0_val};
   assign w_push_data[1] = {src1_vregid, src1_val};
   assign w_push_data[2] = {src2_vregid, src2_val};
   assign w_push_data[3] = {src3_vregid, src3_val};

   // Round-robin scan from r_rr: first up to three non-empty FIFOs win, in scan order
   always_comb begin
      logic [1:0] v_idx;
      logic [1:0] v_n;
      w_grant   = '0;
      w_rr_next = r_rr;
      v_idx     = '0;
      v_n       = '0;
      for (int p = 0; p < NWB; p++) begin
         w_sel[p]     = '0;
         w_sel_vld[p] = 1'b0;
      end
      for (int k = 0; k < NSRC; k++) begin
         v_idx = r_rr + 2'(k);
         if ((r_count[v_idx] != '0) && (v_n < 2'(NWB))) begin
            w_grant[v_idx] = 1'b1;
            w_sel[v_n]     = v_idx;
            w_sel_vld[v_n] = 1'b1;
            w_rr_next      = v_idx + 2'd1;
            v_n            = v_n + 2'd1;
         end
      end
   end

   // A full FIFO still accepts a push when it is drained in the same cycle
   always_comb begin
      for (int s = 0; s < NSRC; s++) begin
         w_push_acc[s] = w_push_en[s] && !flush &&
                         ((r_count[s] != CW'(DEPTH)) || w_grant[s]);
         w_drop[s]     = w_push_en[s] && !flush &&
                         (r_count[s] == CW'(DEPTH)) && !w_grant[s];
      end
   end

   // FIFO pointers and counts
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int s = 0; s < NSRC; s++) begin
            r_wptr[s]  <= '0;
            r_rptr[s]  <= '0;
            r_count[s] <= '0;
         end
      end else if (flush) begin
         for (int s = 0; s < NSRC; s++) begin
            r_wptr[s]  <= '0;
            r_rptr[s]  <= '0;
            r_count[s] <= '0;
         end
      end else begin
         for (int s = 0; s < NSRC; s++) begin
            if (w_grant[s])    r_rptr[s] <= r_rptr[s] + AW'(1);
            if (w_push_acc[s]) r_wptr[s] <= r_wptr[s] + AW'(1);
            r_count[s] <= r_count[s] + CW'(w_push_acc[s]) - CW'(w_grant[s]);
         end
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      for (int s = 0; s < NSRC; s++) begin
         if (w_push_acc[s]) r_mem[s][r_wptr[s]] <= w_push_data[s];
      end
   end

   // Registered broadcast, round-robin pointer and sticky overflow
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rr       <= '0;
         r_overflow <= 1'b0;
         for (int p = 0; p < NWB; p++) begin
            r_wb_en[p]     <= 1'b0;
            r_wb_vregid[p] <= '0;
            r_wb_val[p]    <= '0;
         end
      end else if (flush) begin
         for (int p = 0; p < NWB; p++) begin
            r_wb_en[p]     <= 1'b0;
            r_wb_vregid[p] <= '0;
            r_wb_val[p]    <= '0;
         end
      end else begin
         r_rr       <= w_rr_next;
         r_overflow <= r_overflow | (|w_drop);
         for (int p = 0; p < NWB; p++) begin
            if (w_sel_vld[p]) begin
               r_wb_en[p] <= 1'b1;
               {r_wb_vregid[p], r_wb_val[p]} <= r_mem[w_sel[p]][r_rptr[w_sel[p]]];
            end else begin
               r_wb_en[p]     <= 1'b0;
               r_wb_vregid[p] <= '0;
               r_wb_val[p]    <= '0;
            end
         end
      end
   end

   assign src0_almost_full  = (r_count[0] >= CW'(DEPTH - 1));
   assign src1_almost_full  = (r_count[1] >= CW'(DEPTH - 1));
   assign src2_almost_full  = (r_count[2] >= CW'(DEPTH - 1));
   assign src3_almost_full  = (r_count[3] >= CW'(DEPTH - 1));

   assign writeback1_en     = r_wb_en[0];
   assign writeback1_vregid = r_wb_vregid[0];
   assign writeback1_val    = r_wb_val[0];
   assign writeback2_en     = r_wb_en[1];
   assign writeback2_vregid = r_wb_vregid[1];
   assign writeback2_val    = r_wb_val[1];
   assign writeback3_en     = r_wb_en[2];
   assign writeback3_vregid = r_wb_vregid[2];
   assign writeback3_val    = r_wb_val[2];
   assign overflow          = r_overflow;

endmodule
